// File: rtl/cc_lives_counter_if.sv
// Pulse inputs and status outputs of the Frogger lives manager.
// The game logic holds the master side; the lives counter holds the slave side.
interface cc_lives_counter_if #(
    parameter int LIVES_COUNTER_DATAWIDTH = 3
);
    logic                               CC_LIVES_COUNTER_start_InHigh;
    logic                               CC_LIVES_COUNTER_hit_InHigh;
    logic                               CC_LIVES_COUNTER_bonus_InHigh;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_COUNTER_lives_Out;
    logic                               CC_LIVES_COUNTER_playing_OutHigh;
    logic                               CC_LIVES_COUNTER_invulnerable_OutHigh;
    logic                               CC_LIVES_COUNTER_gameover_OutHigh;
    logic                               CC_LIVES_COUNTER_lostlife_OutHigh;
    // Registered game state for debug and checkers: 0 IDLE, 1 PLAY, 2 COOLDOWN, 3 GAMEOVER.
    logic [1:0]                         CC_LIVES_COUNTER_state_Out;

    // Pulses are single-cycle and sampled on every rising edge; there is no
    // valid/ready handshake, so a pulse held high counts once per cycle.
    modport master (
        output CC_LIVES_COUNTER_start_InHigh,
        output CC_LIVES_COUNTER_hit_InHigh,
        output CC_LIVES_COUNTER_bonus_InHigh,
        input  CC_LIVES_COUNTER_lives_Out,
        input  CC_LIVES_COUNTER_playing_OutHigh,
        input  CC_LIVES_COUNTER_invulnerable_OutHigh,
        input  CC_LIVES_COUNTER_gameover_OutHigh,
        input  CC_LIVES_COUNTER_lostlife_OutHigh,
        input  CC_LIVES_COUNTER_state_Out
    );

    modport slave (
        input  CC_LIVES_COUNTER_start_InHigh,
        input  CC_LIVES_COUNTER_hit_InHigh,
        input  CC_LIVES_COUNTER_bonus_InHigh,
        output CC_LIVES_COUNTER_lives_Out,
        output CC_LIVES_COUNTER_playing_OutHigh,
        output CC_LIVES_COUNTER_invulnerable_OutHigh,
        output CC_LIVES_COUNTER_gameover_OutHigh,
        output CC_LIVES_COUNTER_lostlife_OutHigh,
        output CC_LIVES_COUNTER_state_Out
    );
endinterface

// File: rtl/cc_lives_counter.sv
// Frogger lives register plus game-state FSM (idle, play, post-hit cooldown, game over).
// Every output is a flop loaded from the next-state logic, so outputs lag inputs by one edge.
module cc_lives_counter #(
    parameter int LIVES_COUNTER_DATAWIDTH = 3,
    parameter int LIVES_INIT              = 3,
    parameter int LIVES_MAX               = 7,
    parameter int COOLDOWN_CYCLES         = 25000000,
    parameter int COOLDOWN_DATAWIDTH      = 25
) (
    input  logic                   CC_LIVES_COUNTER_CLOCK_50,
    input  logic                   CC_LIVES_COUNTER_RESET_InLow,
    cc_lives_counter_if.slave      bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] LP_INIT = LIVES_COUNTER_DATAWIDTH'(LIVES_INIT);
    localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] LP_MAX  = LIVES_COUNTER_DATAWIDTH'(LIVES_MAX);
    localparam logic [LIVES_COUNTER_DATAWIDTH-1:0] LP_ONE  = LIVES_COUNTER_DATAWIDTH'(1);
    localparam logic [COOLDOWN_DATAWIDTH-1:0]      LP_CNT_LOAD = COOLDOWN_DATAWIDTH'(COOLDOWN_CYCLES - 1);

    state_t                             r_state;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] r_lives;
    logic [COOLDOWN_DATAWIDTH-1:0]      r_cnt;
    logic                               r_playing;
    logic                               r_invulnerable;
    logic                               r_gameover;
    logic                               r_lostlife;

    state_t                             w_state_nxt;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] w_lives_nxt;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] w_lives_inc;
    logic [COOLDOWN_DATAWIDTH-1:0]      w_cnt_nxt;
    logic                               w_lostlife_nxt;
    logic                               w_start;
    logic                               w_hit;
    logic                               w_bonus;

    assign w_start = bus.CC_LIVES_COUNTER_start_InHigh;
    assign w_hit   = bus.CC_LIVES_COUNTER_hit_InHigh;
    assign w_bonus = bus.CC_LIVES_COUNTER_bonus_InHigh;

    // Bonus increment that holds at the ceiling instead of wrapping.
    assign w_lives_inc = (r_lives < LP_MAX) ? (r_lives + LP_ONE) : r_lives;

    always_comb begin
        w_state_nxt    = r_state;
        w_lives_nxt    = r_lives;
        w_cnt_nxt      = r_cnt;
        w_lostlife_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = LP_INIT;
                end
            end
            ST_PLAY: begin
                if (w_hit && w_bonus) begin
                    // Bonus cancels the lost life, so this can never end the game.
                    w_state_nxt    = ST_COOLDOWN;
                    w_cnt_nxt      = LP_CNT_LOAD;
                    w_lostlife_nxt = 1'b1;
                end else if (w_hit) begin
                    w_lostlife_nxt = 1'b1;
                    if (r_lives > LP_ONE) begin
                        w_lives_nxt = r_lives - LP_ONE;
                        w_state_nxt = ST_COOLDOWN;
                        w_cnt_nxt   = LP_CNT_LOAD;
                    end else begin
                        w_lives_nxt = '0;
                        w_state_nxt = ST_GAMEOVER;
                    end
                end else if (w_bonus) begin
                    w_lives_nxt = w_lives_inc;
                end
            end
            ST_COOLDOWN: begin
                if (w_bonus) begin
                    w_lives_nxt = w_lives_inc;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_GAMEOVER: begin
                w_lives_nxt = '0;
                if (w_start) begin
                    w_state_nxt = ST_PLAY;
                    w_lives_nxt = LP_INIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lives_nxt = LP_INIT;
            end
        endcase
    end

    always_ff @(posedge CC_LIVES_COUNTER_CLOCK_50 or negedge CC_LIVES_COUNTER_RESET_InLow) begin
        if (!CC_LIVES_COUNTER_RESET_InLow) begin
            r_state        <= ST_IDLE;
            r_lives        <= LP_INIT;
            r_cnt          <= '0;
            r_playing      <= 1'b0;
            r_invulnerable <= 1'b0;
            r_gameover     <= 1'b0;
            r_lostlife     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_lives        <= w_lives_nxt;
            r_cnt          <= w_cnt_nxt;
            r_playing      <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_COOLDOWN);
            r_invulnerable <= (w_state_nxt == ST_COOLDOWN);
            r_gameover     <= (w_state_nxt == ST_GAMEOVER);
            r_lostlife     <= w_lostlife_nxt;
        end
    end

    assign bus.CC_LIVES_COUNTER_lives_Out            = r_lives;
    assign bus.CC_LIVES_COUNTER_playing_OutHigh      = r_playing;
    assign bus.CC_LIVES_COUNTER_invulnerable_OutHigh = r_invulnerable;
    assign bus.CC_LIVES_COUNTER_gameover_OutHigh     = r_gameover;
    assign bus.CC_LIVES_COUNTER_lostlife_OutHigh     = r_lostlife;
    assign bus.CC_LIVES_COUNTER_state_Out            = r_state;
endmodule

// File: tb/tb_cc_lives_counter.sv
// Bench for cc_lives_counter: directed game scenarios with literal expectations,
// then random pulses checked every cycle against a behavioural lives model.
module tb_cc_lives_counter;
  localparam int DW       = 3;
  localparam int L_INIT   = 3;
  localparam int L_MAX    = 7;
  localparam int COOL     = 4;
  localparam int COOL_DW  = 3;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic s_start;
  logic s_hit;
  logic s_bonus;

  cc_lives_counter_if #(.LIVES_COUNTER_DATAWIDTH(DW)) bus ();
  assign bus.CC_LIVES_COUNTER_start_InHigh = s_start;
  assign bus.CC_LIVES_COUNTER_hit_InHigh   = s_hit;
  assign bus.CC_LIVES_COUNTER_bonus_InHigh = s_bonus;

  cc_lives_counter #(
    .LIVES_COUNTER_DATAWIDTH(DW),
    .LIVES_INIT(L_INIT),
    .LIVES_MAX(L_MAX),
    .COOLDOWN_CYCLES(COOL),
    .COOLDOWN_DATAWIDTH(COOL_DW)
  ) dut (
    .CC_LIVES_COUNTER_CLOCK_50(clk),
    .CC_LIVES_COUNTER_RESET_InLow(rst_n),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: lives, whether a game is running, remaining invulnerable cycles
  int m_lives;
  bit m_in_game;
  bit m_over;
  int m_cool_left;
  bit m_lost;

  // scoreboard: one expected lives value per checked cycle
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin
    m_lost = 1'b0;
    if (!rst_n) begin
      m_lives = L_INIT; m_in_game = 0; m_over = 0; m_cool_left = 0;
    end else if (m_over) begin
      if (s_start) begin m_over = 0; m_in_game = 1; m_lives = L_INIT; end
    end else if (!m_in_game) begin
      if (s_start) begin m_in_game = 1; m_lives = L_INIT; end
    end else if (m_cool_left > 0) begin
      if (s_bonus) m_lives = (m_lives + 1 > L_MAX) ? L_MAX : m_lives + 1;
      m_cool_left--;
    end else if (s_hit && s_bonus) begin
      m_lost = 1; m_cool_left = COOL;
    end else if (s_hit) begin
      m_lost = 1;
      m_lives--;
      if (m_lives == 0) begin m_in_game = 0; m_over = 1; end
      else m_cool_left = COOL;
    end else if (s_bonus) begin
      m_lives = (m_lives + 1 > L_MAX) ? L_MAX : m_lives + 1;
    end
    exp_q.push_back(DW'(m_lives));
    #1;
    check("m_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), int'(exp_q.pop_front()));
    check("m_playing", int'(bus.CC_LIVES_COUNTER_playing_OutHigh), int'(m_in_game));
    check("m_invuln", int'(bus.CC_LIVES_COUNTER_invulnerable_OutHigh), int'(m_cool_left > 0));
    check("m_gameover", int'(bus.CC_LIVES_COUNTER_gameover_OutHigh), int'(m_over));
    check("m_lostlife", int'(bus.CC_LIVES_COUNTER_lostlife_OutHigh), int'(m_lost));
  end

  // driver: apply pulses for one edge, then observe just after it
  task automatic step(input bit s, input bit h, input bit b);
    @(negedge clk);
    s_start = s; s_hit = h; s_bonus = b;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  int inv_cycles;

  initial begin
    s_start = 0; s_hit = 0; s_bonus = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 3);
    check("rst_playing", int'(bus.CC_LIVES_COUNTER_playing_OutHigh), 0);
    check("rst_gameover", int'(bus.CC_LIVES_COUNTER_gameover_OutHigh), 0);
    check("rst_state", int'(bus.CC_LIVES_COUNTER_state_Out), 0);

    step(0, 1, 0);
    check("idle_hit_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 3);
    check("idle_hit_lost", int'(bus.CC_LIVES_COUNTER_lostlife_OutHigh), 0);

    step(1, 0, 0);
    check("start_playing", int'(bus.CC_LIVES_COUNTER_playing_OutHigh), 1);
    step(0, 1, 0);
    check("hit1_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 2);
    check("hit1_lost", int'(bus.CC_LIVES_COUNTER_lostlife_OutHigh), 1);
    inv_cycles = 1;
    step(0, 1, 0);
    check("cool_hit_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 2);
    check("cool_hit_lost", int'(bus.CC_LIVES_COUNTER_lostlife_OutHigh), 0);
    if (bus.CC_LIVES_COUNTER_invulnerable_OutHigh) inv_cycles++;
    for (int i = 0; i < 20 && bus.CC_LIVES_COUNTER_invulnerable_OutHigh; i++) begin
      step(0, 0, 0);
      if (bus.CC_LIVES_COUNTER_invulnerable_OutHigh) inv_cycles++;
    end
    check("cool_len", inv_cycles, 4);

    step(0, 1, 0);
    check("hit2_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 1);
    idle_steps(4);
    step(0, 1, 1);
    check("hb_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 1);
    check("hb_invuln", int'(bus.CC_LIVES_COUNTER_invulnerable_OutHigh), 1);
    check("hb_lost", int'(bus.CC_LIVES_COUNTER_lostlife_OutHigh), 1);
    check("hb_gameover", int'(bus.CC_LIVES_COUNTER_gameover_OutHigh), 0);
    idle_steps(4);
    step(0, 1, 0);
    check("fatal_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 0);
    check("fatal_gameover", int'(bus.CC_LIVES_COUNTER_gameover_OutHigh), 1);
    check("fatal_playing", int'(bus.CC_LIVES_COUNTER_playing_OutHigh), 0);
    check("fatal_lost", int'(bus.CC_LIVES_COUNTER_lostlife_OutHigh), 1);
    step(0, 0, 1);
    check("go_bonus_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 0);
    step(1, 0, 0);
    check("restart_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 3);
    check("restart_gameover", int'(bus.CC_LIVES_COUNTER_gameover_OutHigh), 0);

    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1);
      check("sat_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), (4 + i > 7) ? 7 : 4 + i);
    end

    step(0, 1, 0);
    check("pre_rst_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 6);
    step(0, 0, 0);
    #1;
    rst_n = 0;
    #1;
    check("async_lives", int'(bus.CC_LIVES_COUNTER_lives_Out), 3);
    check("async_invuln", int'(bus.CC_LIVES_COUNTER_invulnerable_OutHigh), 0);
    check("async_state", int'(bus.CC_LIVES_COUNTER_state_Out), 0);
    s_start = 0; s_hit = 0; s_bonus = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    s_start = 0; s_hit = 0; s_bonus = 0;
    @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
